// File: rtl/cache_mem_arb_pkg.sv
// Shared types and constants for the I/D cache miss-fill memory arbiter.
// Holds the arbiter state enum, the default block geometry and memory latency,
// and the mask that reduces a byte address to its 16-byte block base.
package cache_mem_arb_pkg;

   localparam int unsigned ADDR_W        = 16;
   localparam int unsigned DATA_W        = 16;
   localparam int unsigned CNT_W         = 3;
   localparam int unsigned BLK_WORDS_DEF = 8;
   localparam int unsigned MEM_LAT_DEF   = 4;

   localparam logic [ADDR_W-1:0] BLK_MASK = 16'hFFF0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache/memory side bundle of the miss-fill arbiter.
// slave  : arbiter view (takes cache requests and memory returns, drives the rest).
// master : environment view (caches plus main memory).
interface cache_mem_arbiter_if;
   import cache_mem_arb_pkg::*;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_wr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              fill_valid;
   logic              fill_to_d;
   logic [CNT_W-1:0]  fill_word;
   logic [DATA_W-1:0] fill_data;
   logic              i_busy;
   logic              d_busy;
   logic              i_done;
   logic              d_done;
   logic              wr_done;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_rvalid,
      output mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_to_d, fill_word,
             fill_data, i_busy, d_busy, i_done, d_done, wr_done
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_rvalid,
      input  mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_to_d, fill_word,
             fill_data, i_busy, d_busy, i_done, d_done, wr_done
   );

endinterface

// File: rtl/cache_mem_arb_word_cnt.sv
// Block word counter: wraps from LAST back to 0.
// Ports: clk, rst_n (sync, active-low), en_i (advance), clr_i (to 0, wins over en_i),
//        cnt_o (current index), last_o (cnt_o == LAST, registered alongside the count).
module cache_mem_arb_word_cnt
   import cache_mem_arb_pkg::*;
#(
   parameter logic [CNT_W-1:0] LAST = CNT_W'(BLK_WORDS_DEF - 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q;

   // Next count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // last is precomputed from cnt_d so it stays a flop output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         last_q <= (LAST == '0);
      end else begin
         cnt_q  <= cnt_d;
         last_q <= (cnt_d == LAST);
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = last_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache fills, D-cache fills and D-cache
// write-through stores.
// Ports: clk, rst_n (sync, active-low), bus_io (slave modport: cache requests,
//        memory return in; memory strobe/address/data, fill stream, busy and
//        done pulses out). Every bus_io output is a flop.
module cache_mem_arbiter
   import cache_mem_arb_pkg::*;
#(
   parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
   parameter int unsigned BLK_WORDS = BLK_WORDS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   cache_mem_arbiter_if.slave  bus_io
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLK_WORDS - 1);
   // Returns are expected from a pipelined memory; a zero-latency part is not supported
   localparam bit               LAT_OK    = (MEM_LAT != 0);

   arb_state_e        state_q;
   logic              last_d_q, to_d_q, ret_all_q;
   logic [ADDR_W-1:0] base_q;
   logic              mem_en_q, mem_wr_q, fill_valid_q, fill_to_d_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, fill_data_q;
   logic [CNT_W-1:0]  fill_word_q;
   logic              i_busy_q, d_busy_q, i_done_q, d_done_q, wr_done_q;

   logic              d_any_c, pick_i_c, pick_wr_c, pick_df_c;
   logic              cnt_clr_c, iss_en_c, ret_en_c;
   logic [CNT_W-1:0]  iss_cnt, ret_cnt, iss_nxt_c;
   logic              iss_last, ret_last;

   // Grant selection and counter controls
   always_comb begin
      d_any_c   = bus_io.d_wr || bus_io.d_req;
      // I wins over a pending D only when D had the previous grant
      pick_i_c  = bus_io.i_req && (!d_any_c || last_d_q);
      pick_wr_c = !pick_i_c && bus_io.d_wr;
      pick_df_c = !pick_i_c && !bus_io.d_wr && bus_io.d_req;
      cnt_clr_c = (state_q == ST_IDLE);
      iss_en_c  = (state_q == ST_FILL) && mem_en_q && !iss_last;
      ret_en_c  = (state_q == ST_FILL) && bus_io.mem_rvalid && !ret_all_q && LAT_OK;
      iss_nxt_c = iss_cnt + CNT_W'(1);
   end

   cache_mem_arb_word_cnt #(.LAST(LAST_WORD)) u_iss_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (iss_en_c),
      .clr_i  (cnt_clr_c),
      .cnt_o  (iss_cnt),
      .last_o (iss_last)
   );

   cache_mem_arb_word_cnt #(.LAST(LAST_WORD)) u_ret_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (ret_en_c),
      .clr_i  (cnt_clr_c),
      .cnt_o  (ret_cnt),
      .last_o (ret_last)
   );

   // Arbiter FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_d_q     <= 1'b0;
         to_d_q       <= 1'b0;
         ret_all_q    <= 1'b0;
         base_q       <= '0;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fill_valid_q <= 1'b0;
         fill_to_d_q  <= 1'b0;
         fill_word_q  <= '0;
         fill_data_q  <= '0;
         i_busy_q     <= 1'b0;
         d_busy_q     <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         wr_done_q    <= 1'b0;
      end else begin
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         fill_valid_q <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         wr_done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_wr_c) begin
                  state_q     <= ST_WRITE;
                  mem_en_q    <= 1'b1;
                  mem_wr_q    <= 1'b1;
                  mem_addr_q  <= bus_io.d_addr;
                  mem_wdata_q <= bus_io.d_wdata;
                  wr_done_q   <= 1'b1;
                  d_busy_q    <= 1'b1;
                  last_d_q    <= 1'b1;
               end else if (pick_df_c) begin
                  state_q    <= ST_FILL;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= bus_io.d_addr & BLK_MASK;
                  base_q     <= bus_io.d_addr & BLK_MASK;
                  to_d_q     <= 1'b1;
                  d_busy_q   <= 1'b1;
                  last_d_q   <= 1'b1;
               end else if (pick_i_c) begin
                  state_q    <= ST_FILL;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= bus_io.i_addr & BLK_MASK;
                  base_q     <= bus_io.i_addr & BLK_MASK;
                  to_d_q     <= 1'b0;
                  i_busy_q   <= 1'b1;
                  last_d_q   <= 1'b0;
               end
            end
            ST_WRITE: begin
               state_q  <= ST_IDLE;
               d_busy_q <= 1'b0;
            end
            ST_FILL: begin
               // word 0 went out with the grant; issue the rest back to back
               if (iss_en_c) begin
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= base_q + ADDR_W'({iss_nxt_c, 1'b0});
               end
               if (ret_en_c) begin
                  fill_valid_q <= 1'b1;
                  fill_to_d_q  <= to_d_q;
                  fill_word_q  <= ret_cnt;
                  fill_data_q  <= bus_io.mem_rdata;
                  if (ret_last) begin
                     ret_all_q <= 1'b1;
                  end
               end
               // done follows the cycle that presents the last fill word
               if (ret_all_q) begin
                  state_q  <= ST_DONE;
                  i_done_q <= !to_d_q;
                  d_done_q <= to_d_q;
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               ret_all_q <= 1'b0;
               i_busy_q  <= 1'b0;
               d_busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus_io.mem_en     = mem_en_q;
   assign bus_io.mem_wr     = mem_wr_q;
   assign bus_io.mem_addr   = mem_addr_q;
   assign bus_io.mem_wdata  = mem_wdata_q;
   assign bus_io.fill_valid = fill_valid_q;
   assign bus_io.fill_to_d  = fill_to_d_q;
   assign bus_io.fill_word  = fill_word_q;
   assign bus_io.fill_data  = fill_data_q;
   assign bus_io.i_busy     = i_busy_q;
   assign bus_io.d_busy     = d_busy_q;
   assign bus_io.i_done     = i_done_q;
   assign bus_io.d_done     = d_done_q;
   assign bus_io.wr_done    = wr_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: I fill, D-over-I priority, store then
// fill, D/I alternation, and reset in the middle of a fill. A pipelined memory
// model returns (address ^ 16'hA5A5) MEM_LAT cycles after each read strobe.
module tb_cache_mem_arbiter;
   import cache_mem_arb_pkg::*;

   localparam int unsigned ML     = 4;
   localparam int          FV0    = 2 + int'(ML);
   localparam int          DONE_C = 10 + int'(ML);

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   int    n_assert = 0;
   int    n_fail   = 0;
   string phase    = "init";

   cache_mem_arbiter_if bus ();

   cache_mem_arbiter #(.MEM_LAT(ML), .BLK_WORDS(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Memory model: read strobe in cycle C returns in cycle C+ML
   logic [ML:1] rv_pipe = '0;
   logic [15:0] rd_pipe [1:ML];
   always @(posedge clk) begin
      rv_pipe[1] <= bus.mem_en && !bus.mem_wr;
      rd_pipe[1] <= bus.mem_addr ^ 16'hA5A5;
      for (int s = 2; s <= int'(ML); s++) begin
         rv_pipe[s] <= rv_pipe[s-1];
         rd_pipe[s] <= rd_pipe[s-1];
      end
   end
   assign bus.mem_rvalid = rv_pipe[ML];
   assign bus.mem_rdata  = rd_pipe[ML];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %b expected %b", phase, tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_zero();
      chk1 ("mem_en",     bus.mem_en,     1'b0);
      chk1 ("mem_wr",     bus.mem_wr,     1'b0);
      chk16("mem_addr",   bus.mem_addr,   16'h0000);
      chk16("mem_wdata",  bus.mem_wdata,  16'h0000);
      chk1 ("fill_valid", bus.fill_valid, 1'b0);
      chk1 ("fill_to_d",  bus.fill_to_d,  1'b0);
      chk16("fill_word",  16'(bus.fill_word), 16'h0000);
      chk16("fill_data",  bus.fill_data,  16'h0000);
      chk1 ("i_busy",     bus.i_busy,     1'b0);
      chk1 ("d_busy",     bus.d_busy,     1'b0);
      chk1 ("i_done",     bus.i_done,     1'b0);
      chk1 ("d_done",     bus.d_done,     1'b0);
      chk1 ("wr_done",    bus.wr_done,    1'b0);
   endtask

   // Call in the IDLE cycle T in which the request is presented; returns at the done cycle
   task automatic expect_fill(input logic to_d, input logic [15:0] base);
      for (int c = 1; c <= DONE_C; c++) begin
         logic        en_e, fv_e, dn_e;
         logic [15:0] w;
         cyc();
         en_e = (c <= 8);
         fv_e = (c >= FV0) && (c <= FV0 + 7);
         dn_e = (c == DONE_C);
         chk1("mem_en", bus.mem_en, en_e);
         if (en_e) begin
            chk16("mem_addr", bus.mem_addr, base + 16'(2 * (c - 1)));
            chk1 ("mem_wr",   bus.mem_wr,   1'b0);
         end
         chk1("fill_valid", bus.fill_valid, fv_e);
         if (fv_e) begin
            w = 16'(c - FV0);
            chk16("fill_word", 16'(bus.fill_word), w);
            chk16("fill_data", bus.fill_data, (base + {w[14:0], 1'b0}) ^ 16'hA5A5);
            chk1 ("fill_to_d", bus.fill_to_d, to_d);
         end
         chk1("i_done",  bus.i_done,  dn_e && !to_d);
         chk1("d_done",  bus.d_done,  dn_e && to_d);
         chk1("wr_done", bus.wr_done, 1'b0);
         chk1("i_busy",  bus.i_busy,  !to_d);
         chk1("d_busy",  bus.d_busy,  to_d);
      end
   endtask

   initial begin
      bus.i_req   = 1'b0;
      bus.i_addr  = 16'h0000;
      bus.d_req   = 1'b0;
      bus.d_addr  = 16'h0000;
      bus.d_wr    = 1'b0;
      bus.d_wdata = 16'h0000;

      phase = "reset";
      rst_n = 1'b0;
      repeat (3) cyc();
      check_zero();
      rst_n = 1'b1;
      cyc();

      // Single I fill from a mid-block address
      phase = "i_fill";
      bus.i_addr = 16'h0046;
      bus.i_req  = 1'b1;
      expect_fill(1'b0, 16'h0040);
      bus.i_req = 1'b0;
      cyc();
      chk1("idle.mem_en", bus.mem_en, 1'b0);
      chk1("idle.i_busy", bus.i_busy, 1'b0);

      // D and I raised together: D first, I granted in the cycle after d_done
      phase = "d_then_i";
      bus.d_addr = 16'h2ABC;
      bus.d_req  = 1'b1;
      bus.i_addr = 16'h0107;
      bus.i_req  = 1'b1;
      expect_fill(1'b1, 16'h2AB0);
      bus.d_req = 1'b0;
      cyc();
      chk1("gap.mem_en", bus.mem_en, 1'b0);
      chk1("gap.d_busy", bus.d_busy, 1'b0);
      chk1("gap.i_busy", bus.i_busy, 1'b0);
      expect_fill(1'b0, 16'h0100);

      // Both held continuously: D, I, D
      phase = "alternate";
      bus.d_addr = 16'h5558;
      bus.d_req  = 1'b1;
      cyc();
      expect_fill(1'b1, 16'h5550);
      cyc();
      expect_fill(1'b0, 16'h0100);
      cyc();
      expect_fill(1'b1, 16'h5550);
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
      cyc();

      // Store with a fill queued behind it
      phase = "write";
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h1234;
      bus.d_wdata = 16'hBEEF;
      bus.d_req   = 1'b1;
      cyc();
      chk1 ("wr.mem_en",    bus.mem_en,    1'b1);
      chk1 ("wr.mem_wr",    bus.mem_wr,    1'b1);
      chk16("wr.mem_addr",  bus.mem_addr,  16'h1234);
      chk16("wr.mem_wdata", bus.mem_wdata, 16'hBEEF);
      chk1 ("wr.wr_done",   bus.wr_done,   1'b1);
      chk1 ("wr.d_busy",    bus.d_busy,    1'b1);
      chk1 ("wr.i_busy",    bus.i_busy,    1'b0);
      bus.d_wr   = 1'b0;
      bus.d_addr = 16'h3456;
      cyc();
      chk1("post_wr.mem_en",  bus.mem_en,  1'b0);
      chk1("post_wr.wr_done", bus.wr_done, 1'b0);
      chk1("post_wr.d_busy",  bus.d_busy,  1'b0);
      expect_fill(1'b1, 16'h3450);
      bus.d_req = 1'b0;
      cyc();

      // Reset at the third fill word; stray returns afterwards must be dropped
      phase = "reset_mid";
      bus.i_addr = 16'h00F2;
      bus.i_req  = 1'b1;
      repeat (FV0 + 2) cyc();
      chk1 ("third.fill_valid", bus.fill_valid, 1'b1);
      chk16("third.fill_word",  16'(bus.fill_word), 16'h0002);
      rst_n     = 1'b0;
      bus.i_req = 1'b0;
      cyc();
      check_zero();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk1("after.fill_valid", bus.fill_valid, 1'b0);
         chk1("after.i_done",     bus.i_done,     1'b0);
         chk1("after.mem_en",     bus.mem_en,     1'b0);
         chk1("after.i_busy",     bus.i_busy,     1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
